// File: rtl/uart_tx_fifo_if.sv
// Producer-side bundle for uart_tx_fifo: write port, FIFO status, serial
// line and FSM state for checkers.
//
// Handshake: a byte is accepted on a rising clk edge where wen=1 and full=0.
// A wen=1 edge while full=1 is dropped and answered by a one-cycle overflow
// pulse. There is no backpressure beyond full; the producer must watch it.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] din;
  logic                 wen;
  logic                 full;
  logic                 overflow;
  logic [LW-1:0]        level;
  logic                 busy;
  logic                 txd;
  logic [2:0]           state_dbg;

  modport master (
    output din, wen,
    input  full, overflow, level, busy, txd, state_dbg
  );

  modport slave (
    input  din, wen,
    output full, overflow, level, busy, txd, state_dbg
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO. Frames are start bit, DATA_BITS data
// bits LSB first, optional parity bit, then STOP_BITS stop bits. The baud
// counter is held at zero while idle so each frame begins with a full bit.
// txd and busy are registered: they follow the FSM state one cycle later.
module uart_tx_fifo #(
  parameter int FREQ       = 27000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_fifo_if.slave    bus
);

  localparam int BIT_CLKS = FREQ / BAUD;
  localparam int CW       = $clog2(BIT_CLKS);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] tx_data, tx_data_n;
  logic                 txd_n;
  logic                 txd_q;
  logic                 busy_q;
  logic                 overflow_q;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 bit_end;

  // full comes from the registered level, so a pop in the same cycle does
  // not open a slot for a write already presented against full.
  assign full    = (level == LW'(FIFO_DEPTH));
  assign push    = bus.wen & ~full;
  assign bit_end = (cnt == CW'(BIT_CLKS - 1));

  assign bus.full      = full;
  assign bus.overflow  = overflow_q;
  assign bus.level     = level;
  assign bus.busy      = busy_q;
  assign bus.txd       = txd_q;
  assign bus.state_dbg = state;

  // Next-state, baud/bit counters, FIFO pop and line level for the current state.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    tx_data_n = tx_data;
    pop       = 1'b0;
    txd_n     = 1'b1;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (level != '0) begin
          pop       = 1'b1;
          tx_data_n = mem[rd_ptr];
          idx_n     = '0;
          state_n   = S_START;
        end
      end
      S_START: begin
        txd_n = 1'b0;
        if (bit_end) begin
          cnt_n   = '0;
          state_n = S_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DATA: begin
        txd_n = tx_data[idx];
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'(DATA_BITS - 1)) begin
            idx_n   = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_PARITY: begin
        // Odd parity is the inverse of the data XOR.
        txd_n = (PARITY == 1) ? ~(^tx_data) : (^tx_data);
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = S_STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_STOP: begin
        txd_n = 1'b1;
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'(STOP_BITS - 1)) begin
            idx_n = '0;
            // Chain straight into the next frame when data is waiting.
            if (level != '0) begin
              pop       = 1'b1;
              tx_data_n = mem[rd_ptr];
              state_n   = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  // FSM state, counters, shift data and registered line/busy/overflow outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      tx_data    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      tx_data    <= tx_data_n;
      txd_q      <= txd_n;
      busy_q     <= (state != S_IDLE) | (level != '0);
      overflow_q <= bus.wen & full;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.din;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. Three instances at BIT_CLKS=10, FIFO_DEPTH=4:
//   0: 8N1   1: 7 data, even parity, 2 stop   2: 7 data, odd parity, 2 stop
// Directed writes push the hand-built expected frame (bit 0 = start bit) into
// a per-instance queue; a line monitor per instance pops it when a start bit
// appears and compares every cycle of the frame.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_a     [3];
  logic [7:0] din_a     [3];
  logic       wen_a     [3];
  logic       txd_a     [3];
  logic       busy_a    [3];
  logic       full_a    [3];
  logic       ovf_a     [3];
  logic [2:0] level_a   [3];
  logic [2:0] state_a   [3];

  int checks;
  int failures;
  int cyc;

  logic [11:0] exp_q0[$];
  logic [11:0] exp_q1[$];
  logic [11:0] exp_q2[$];
  int          start_log[$];

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push_exp(input int g, input logic [11:0] fr);
    case (g)
      0:       exp_q0.push_back(fr);
      1:       exp_q1.push_back(fr);
      default: exp_q2.push_back(fr);
    endcase
  endfunction

  function automatic logic pop_exp(input int g, output logic [11:0] fr);
    fr = '0;
    case (g)
      0:       if (exp_q0.size() == 0) return 1'b0; else fr = exp_q0.pop_front();
      1:       if (exp_q1.size() == 0) return 1'b0; else fr = exp_q1.pop_front();
      default: if (exp_q2.size() == 0) return 1'b0; else fr = exp_q2.pop_front();
    endcase
    return 1'b1;
  endfunction

  function automatic void log_start(input int g);
    if (g == 0) start_log.push_back(cyc);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DB  = (g == 0) ? 8 : 7;
    localparam int PAR = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
    localparam int SB  = (g == 0) ? 1 : 2;
    localparam int NB  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;

    uart_tx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(4)) bus ();

    uart_tx_fifo #(
      .FREQ(1000), .BAUD(100), .DATA_BITS(DB), .PARITY(PAR),
      .STOP_BITS(SB), .FIFO_DEPTH(4)
    ) dut (
      .clk (clk),
      .rst (rst_a[g]),
      .bus (bus)
    );

    assign bus.din    = din_a[g][DB-1:0];
    assign bus.wen    = wen_a[g];
    assign txd_a[g]   = bus.txd;
    assign busy_a[g]  = bus.busy;
    assign full_a[g]  = bus.full;
    assign ovf_a[g]   = bus.overflow;
    assign level_a[g] = bus.level;
    assign state_a[g] = bus.state_dbg;

    // scoreboard monitor: one frame comparison per start bit seen on the line
    initial begin : mon
      logic [11:0] fr;
      logic        bad;
      logic        aborted;
      int          bad_b;
      int          bad_c;
      logic        bad_v;
      forever begin
        @(negedge clk);
        if (rst_a[g] === 1'b0 && txd_a[g] === 1'b0) begin
          log_start(g);
          if (!pop_exp(g, fr)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame dut%0d actual=frame_started required=no_frame", g);
          end
          bad     = 1'b0;
          aborted = 1'b0;
          bad_b   = 0;
          bad_c   = 0;
          bad_v   = 1'b0;
          for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < 10; c++) begin
              if (!(b == 0 && c == 0)) @(negedge clk);
              if (rst_a[g] !== 1'b0) aborted = 1'b1;
              else if (!aborted && !bad && txd_a[g] !== fr[b]) begin
                bad   = 1'b1;
                bad_b = b;
                bad_c = c;
                bad_v = txd_a[g];
              end
            end
          end
          if (!aborted) begin
            checks++;
            if (bad) begin
              failures++;
              $display("FAIL frame_dut%0d bit=%0d cycle=%0d actual_txd=%b required_txd=%b frame=%03h",
                       g, bad_b, bad_c, bad_v, fr[bad_b], fr);
            end
          end
        end
      end
    end
  end

  // driver tasks
  task automatic write(input int g, input logic [7:0] d, input logic [11:0] fr);
    wen_a[g] = 1'b1;
    din_a[g] = d;
    push_exp(g, fr);
    step();
    wen_a[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input int limit, input string name);
    int n;
    n = 0;
    while (busy_a[g] !== 1'b0 && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) chk(name, 32'(busy_a[g]), 32'd0);
  endtask

  task automatic frame_len(input int g, input int len);
    int n;
    n = 0;
    while (txd_a[g] !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    chk($sformatf("start_latency_dut%0d", g), n, 2);
    n = 0;
    while (busy_a[g] !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    chk($sformatf("frame_len_dut%0d", g), n, len);
  endtask

  logic [7:0] burst [6];
  int         n_bad;
  int         n_start;

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    burst    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int g = 0; g < 3; g++) begin
      rst_a[g] = 1'b1;
      wen_a[g] = 1'b0;
      din_a[g] = 8'h00;
    end
    step();
    step();

    // reset values
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_txd_dut%0d", g), 32'(txd_a[g]), 32'd1);
      chk($sformatf("rst_busy_dut%0d", g), 32'(busy_a[g]), 32'd0);
      chk($sformatf("rst_level_dut%0d", g), 32'(level_a[g]), 32'd0);
      chk($sformatf("rst_full_dut%0d", g), 32'(full_a[g]), 32'd0);
      chk($sformatf("rst_ovf_dut%0d", g), 32'(ovf_a[g]), 32'd0);
      chk($sformatf("rst_state_dut%0d", g), 32'(state_a[g]), 32'd0);
      rst_a[g] = 1'b0;
    end

    // idle hold for 100 cycles
    n_bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      for (int g = 0; g < 3; g++)
        if (txd_a[g] !== 1'b1 || busy_a[g] !== 1'b0 || level_a[g] !== 3'd0) n_bad++;
    end
    chk("idle_hold_bad_cycles", n_bad, 0);

    // single 8N1 frame, 0xA5 -> line 0,1,0,1,0,0,1,0,1,1
    write(0, 8'hA5, {1'b1, 8'hA5, 1'b0});
    chk("single_level_after_write", 32'(level_a[0]), 32'd1);
    step();
    chk("single_level_after_pop", 32'(level_a[0]), 32'd0);
    chk("single_txd_before_start", 32'(txd_a[0]), 32'd1);
    step();
    chk("single_txd_start", 32'(txd_a[0]), 32'd0);
    n_bad = 0;
    while (busy_a[0] !== 1'b0 && n_bad < 300) begin
      step();
      n_bad++;
    end
    chk("single_busy_drop", n_bad, 100);
    repeat (5) step();

    // 7E2: 0x55 -> data 1,0,1,0,1,0,1, parity 0, two stops; 110 cycles
    write(1, 8'h55, {2'b11, 1'b0, 7'h55, 1'b0});
    frame_len(1, 110);
    // 7O2: same data, parity 1
    write(2, 8'h55, {2'b11, 1'b1, 7'h55, 1'b0});
    frame_len(2, 110);
    // 7E2 with odd popcount: 0x07 has three ones -> even parity bit 1
    write(1, 8'h07, {2'b11, 1'b1, 7'h07, 1'b0});
    frame_len(1, 110);
    repeat (5) step();

    // burst of 6 into depth 4: five accepted, sixth overflows
    start_log.delete();
    for (int i = 0; i < 6; i++) begin
      wen_a[0] = 1'b1;
      din_a[0] = burst[i];
      if (i < 5) push_exp(0, {1'b1, burst[i], 1'b0});
      step();
      if (i == 4) begin
        chk("burst_ovf_before_reject", 32'(ovf_a[0]), 32'd0);
        chk("burst_full", 32'(full_a[0]), 32'd1);
      end
    end
    wen_a[0] = 1'b0;
    chk("burst_ovf_pulse", 32'(ovf_a[0]), 32'd1);
    chk("burst_full_at_reject", 32'(full_a[0]), 32'd1);
    chk("burst_level_at_reject", 32'(level_a[0]), 32'd4);
    step();
    chk("burst_ovf_one_cycle", 32'(ovf_a[0]), 32'd0);
    wait_idle(0, 700, "burst_timeout_busy");
    chk("burst_frame_count", start_log.size(), 5);
    for (int i = 1; i < 5 && i < start_log.size(); i++)
      chk($sformatf("burst_gap_%0d", i), start_log[i] - start_log[i-1], 100);
    repeat (5) step();

    // push on the exact STOP->START pop edge
    start_log.delete();
    write(0, 8'h3C, {1'b1, 8'h3C, 1'b0});
    write(0, 8'hC3, {1'b1, 8'hC3, 1'b0});
    repeat (99) step();
    chk("simul_level_before", 32'(level_a[0]), 32'd1);
    write(0, 8'h5A, {1'b1, 8'h5A, 1'b0});
    chk("simul_level_unchanged", 32'(level_a[0]), 32'd1);
    wait_idle(0, 400, "simul_timeout_busy");
    chk("simul_frame_count", start_log.size(), 3);
    if (start_log.size() == 3) chk("simul_gap", start_log[2] - start_log[1], 100);
    repeat (5) step();

    // reset during data bit 3 with two bytes queued
    write(0, 8'hF0, {1'b1, 8'hF0, 1'b0});
    write(0, 8'h0F, {1'b1, 8'h0F, 1'b0});
    write(0, 8'h99, {1'b1, 8'h99, 1'b0});
    chk("rstmid_level_queued", 32'(level_a[0]), 32'd2);
    repeat (44) step();
    rst_a[0] = 1'b1;
    step();
    rst_a[0] = 1'b0;
    exp_q0.delete();
    chk("rstmid_txd", 32'(txd_a[0]), 32'd1);
    chk("rstmid_level", 32'(level_a[0]), 32'd0);
    chk("rstmid_busy", 32'(busy_a[0]), 32'd0);
    n_start = start_log.size();
    n_bad   = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (txd_a[0] !== 1'b1 || busy_a[0] !== 1'b0) n_bad++;
    end
    chk("rstmid_quiet_bad_cycles", n_bad, 0);
    chk("rstmid_no_new_frames", start_log.size(), n_start);

    repeat (20) step();
    chk("exp_queues_drained", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO. Supports configurable data width, optional parity and one or two stop bits. Sits between on-chip producers (debug/log logic, soft-CPU peripheral bus) and the board UART pin. Producers can burst several bytes without polling per byte.

## Interface

Parameters:
- FREQ, 27000000: clock frequency in Hz.
- BAUD, 115200: line rate in bit/s. BIT_CLKS = FREQ/BAUD (integer division), which must be ≥ 2.
- DATA_BITS, 8: payload bits per frame, legal range 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: entries, a power of 2, ≥ 2.

Ports:
- clk, input, 1: sole clock.
- rst, input, 1: synchronous, active-high reset.
- din, input, DATA_BITS: write data.
- wen, input, 1: write strobe, sampled on the rising edge of clk.
- full, output, 1: FIFO full; writes are rejected while this is high.
- overflow, output, 1: one-cycle pulse when wen is high while full is high.
- level, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- busy, output, 1: high while the FIFO is non-empty or a frame is in flight.
- txd, output, 1: serial line, idle high.

## Operation

- Reset values: txd=1, full=0, overflow=0, level=0, busy=0, FSM in IDLE, FIFO empty, baud counter 0.
- Reset during a frame aborts the frame and flushes the FIFO. txd reads 1 from the cycle after the reset edge.
- Write handshake:
  - wen=1 and full=0 pushes din.
  - wen=1 and full=1 drops the data and pulses overflow for 1 cycle. FIFO contents are unchanged.
  - full is the registered state. A write while full is rejected even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave level unchanged.
- full = (level == FIFO_DEPTH). level wraps neither up nor down: a push is blocked at FIFO_DEPTH, and a pop only happens when level > 0.
- FSM states and transitions:
  - IDLE → START: when FIFO is non-empty. Pop the head into the shift register, clear the baud counter, set the bit index to 0.
  - START: txd=0 for BIT_CLKS cycles, then → DATA.
  - DATA: txd = shift[idx], LSB first, each bit held BIT_CLKS cycles. After bit DATA_BITS-1, go → PARITY if PARITY≠0, else → STOP.
  - PARITY: txd = XOR of the data bits (even), or its inverse (odd), for BIT_CLKS cycles, then → STOP.
  - STOP: txd=1 for STOP_BITS×BIT_CLKS cycles. Then go → START directly if the FIFO is non-empty (pop in the same cycle, back-to-back frames). Otherwise go → IDLE.
- Baud counter:
  - Counts 0..BIT_CLKS-1 and restarts at every bit boundary.
  - Held at 0 in IDLE, so the first bit is always a full bit time. This differs from a free-running tick.
- Unused din bits do not exist: din width equals DATA_BITS.
- An illegal FSM encoding recovers to IDLE with txd=1.
- busy = (state≠IDLE) | (level≠0).

## Timing

- Write-to-line latency, idle block with empty FIFO:
  - wen sampled at edge E.
  - level=1 after E.
  - The pop happens at E+1, and level returns to 0.
  - txd falls after edge E+2.
- Frame length in cycles = BIT_CLKS × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS).
- Back-to-back frames have no idle gap. The next start bit begins on the cycle after the last stop-bit cycle.
- busy falls on the cycle after the last stop-bit cycle when the FIFO is empty.
- overflow is asserted in the cycle after the rejected write edge. It is high for exactly one cycle per rejected write.
- Every bit edge on txd is exactly BIT_CLKS cycles from the previous one within a frame. Jitter is zero.

## Test plan

All scenarios use FREQ=1000 and BAUD=100, so BIT_CLKS=10.

- Reset then idle: with no writes, txd=1, busy=0, and level=0 for 100 cycles.
- Single frame, 8N1: write 0xA5.
  - txd falls 2 cycles after the write.
  - Bit sequence is 0,1,0,1,0,0,1,0,1,1, each 10 cycles.
  - busy drops 100 cycles after txd falls.
- Parity and 2 stop bits: DATA_BITS=7, PARITY=2, STOP_BITS=2. Write 0x55.
  - Data bits are 1,0,1,0,1,0,1.
  - Parity bit is 0.
  - Two stop bits follow, and the frame totals 110 cycles.
  - Repeat with PARITY=1: the parity bit is 1.
- Burst and overflow: FIFO_DEPTH=4.
  - Write 6 bytes on consecutive cycles.
  - 5 are accepted, because the first pops after 1 cycle.
  - The 6th raises overflow for 1 cycle with full=1.
  - 5 frames are sent back-to-back, no gap, in order.
- Simultaneous push and pop: write on the exact cycle a STOP→START pop occurs. level is unchanged, and the byte is sent next.
- Reset mid-frame: assert rst during DATA bit 3 with 2 bytes queued.
  - txd=1 the next cycle.
  - level=0 and busy=0.
  - No further frames are sent.
